// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and state encoding for the memory port arbiter.
package mem_port_arbiter_pkg;

  localparam logic        RamEnable  = 1'b1;
  localparam logic        RamDisable = 1'b0;
  localparam logic        RamWrite   = 1'b1;
  localparam logic        RamUnWrite = 1'b0;
  localparam logic        RstEnable  = 1'b0;
  localparam logic [31:0] Zero       = 32'h0000_0000;

  typedef enum logic [1:0] {
    StIdle,
    StMemAcc,
    StIfAcc,
    StDone
  } state_e;

endpackage

// File: rtl/mem_port_arbiter_bus_timeout_cnt.sv
// Per-transaction cycle counter; tc flags the last allowed access cycle.
module bus_timeout_cnt
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] TcVal = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt_q;

  // Count access cycles; hold at terminal count, restart whenever cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !tc) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tc = (cnt_q == TcVal);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported RAM between instruction fetch and the MEM stage.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifCe,
  input  logic [31:0] ifAddr,
  output logic [31:0] ifData,
  output logic        ifDone,
  input  logic        memCe,
  input  logic        memWr,
  input  logic [31:0] memAddr,
  input  logic [31:0] wtData,
  output logic [31:0] rdData,
  output logic        memDone,
  output logic        ramCe,
  output logic        ramWe,
  output logic [31:0] ramAddr,
  output logic [31:0] ramWdata,
  input  logic [31:0] ramRdata,
  input  logic        ramAck,
  output logic        stall,
  output logic        busErr
);

  state_e      state_q, state_d;
  logic        wr_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] if_data_q, rd_data_q;
  logic        if_done_q, mem_done_q, bus_err_q;
  logic        in_acc, tc, finish, abort;

  assign in_acc = (state_q == StMemAcc) || (state_q == StIfAcc);
  // A transaction ends on ack, or on the last allowed cycle without one.
  assign finish = in_acc && (ramAck || tc);
  assign abort  = in_acc && !ramAck && tc;

  bus_timeout_cnt #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk(clk),
    .rst(rst),
    .clr(!in_acc),
    .en (in_acc),
    .tc (tc)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) state_q <= StIdle;
    else                  state_q <= state_d;
  end

  // Next state: MEM wins in IDLE since it holds the older instruction.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (memCe)     state_d = StMemAcc;
        else if (ifCe) state_d = StIfAcc;
      end
      StMemAcc, StIfAcc: begin
        if (finish) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Capture the granted request so the RAM bus stays stable until ack.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      wr_q    <= RamUnWrite;
      addr_q  <= Zero;
      wdata_q <= Zero;
    end else if (state_q == StIdle) begin
      if (memCe) begin
        wr_q    <= memWr;
        addr_q  <= memAddr;
        wdata_q <= wtData;
      end else if (ifCe) begin
        wr_q    <= RamUnWrite;
        addr_q  <= ifAddr;
        wdata_q <= Zero;
      end
    end
  end

  // Completion: route read data (0 on timeout) to the owner and pulse its done.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      if_data_q  <= Zero;
      rd_data_q  <= Zero;
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      if (finish) begin
        if (state_q == StMemAcc) begin
          mem_done_q <= 1'b1;
          rd_data_q  <= ramAck ? ramRdata : Zero;
        end else begin
          if_done_q <= 1'b1;
          if_data_q <= ramAck ? ramRdata : Zero;
        end
      end
      if (abort) bus_err_q <= 1'b1;
    end
  end

  // RAM bus driven only in access states; idle in IDLE and the DONE bubble.
  always_comb begin
    ramCe    = in_acc ? RamEnable : RamDisable;
    ramWe    = (state_q == StMemAcc && wr_q) ? RamWrite : RamUnWrite;
    ramAddr  = in_acc ? addr_q : Zero;
    ramWdata = (state_q == StMemAcc) ? wdata_q : Zero;
  end

  // Stall while any request lacks its done pulse; forced low during reset.
  assign stall = rst & ((memCe & ~mem_done_q) | (ifCe & ~if_done_q));

  assign ifData  = if_data_q;
  assign ifDone  = if_done_q;
  assign rdData  = rd_data_q;
  assign memDone = mem_done_q;
  assign busErr  = bus_err_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single-ported synchronous data/instruction RAM between the instruction-fetch port and the MEM-stage load/store port (including LL/SC accesses) of the five-stage pipeline. It sequences one RAM transaction at a time, holds read data for the requester, raises a pipeline stall while any granted or pending access is incomplete, and flags a bus timeout. It sits between IF/MEM and the RAM model.

## Interface
- `TIMEOUT`, default 16: RAM cycles allowed per transaction before abort.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `ifCe`  in  1  fetch request.
- `ifAddr`  in  32  fetch byte address.
- `ifData`  out  32  fetched instruction, valid when `ifDone`.
- `ifDone`  out  1  one-cycle pulse, fetch complete.
- `memCe`  in  1  MEM-stage request, level, held until `memDone`.
- `memWr`  in  1  1 = store (`RamWrite`), 0 = load.
- `memAddr`  in  32  data byte address.
- `wtData`  in  32  store data.
- `rdData`  out  32  load data, valid when `memDone`.
- `memDone`  out  1  one-cycle pulse, data access complete.
- `ramCe`, `ramWe`  out  1 each  RAM enable / write enable.
- `ramAddr`, `ramWdata`  out  32 each  RAM address / write data.
- `ramRdata`  in  32  RAM read data, valid with `ramAck`.
- `ramAck`  in  1  RAM completion strobe, variable latency ≥1 cycle.
- `stall`  out  1  freeze IF..MEM.
- `busErr`  out  1  sticky timeout flag, cleared only by reset.

## Operation
- FSM states: IDLE, MEM_ACC, IF_ACC, DONE.
- IDLE: if `memCe` → MEM_ACC (latch addr, wr, data); else if `ifCe` → IF_ACC (latch addr); else stay. MEM has fixed priority: it holds the older instruction.
- MEM_ACC/IF_ACC: drive `ramCe`=1, `ramWe`=latched wr (always 0 for IF), `ramAddr`/`ramWdata` from latches, stable until `ramAck`. On `ramAck`: capture `ramRdata` into requester's data register, pulse its done, go to DONE.
- DONE: one bubble cycle with RAM idle; then IDLE re-arbitrates. A fetch pending behind a MEM access is granted after DONE.
- Timeout counter resets on entering an access state and increments each cycle without `ramAck`; at `TIMEOUT`-1 with no ack: set `busErr`, pulse the requester's done with data 0, go to DONE.
- `stall` = (`memCe` or `ifCe`) and the corresponding done is not pulsing this cycle; also 1 in DONE when a request is still pending.
- Requester data registers hold their last value until the next completion for that port.
- Addresses pass unmodified; alignment checking is out of scope.

## Timing
- Reset (async, `rst`=0): state IDLE, `ramCe`=`RamDisable`, `ramWe`=`RamUnWrite`, `ramAddr`/`ramWdata`/`ifData`/`rdData`=`Zero`, `ifDone`/`memDone`/`stall`/`busErr`=0, counter 0.
- Request sampled in IDLE at edge N; `ramCe` asserted from N+1; `ramAck` at edge N+k gives done pulse in cycle N+k (registered outputs, visible after edge N+k).
- Minimum transaction: 3 cycles (grant, access with ack, DONE).
- Simultaneous `memCe` and `ifCe` in IDLE: MEM granted, IF waits, `stall`=1 throughout.
- Request withdrawn mid-access: access completes anyway, done still pulses; requester ignores it.
- `ramAck` outside an access state: ignored.
- Reset mid-access: immediate return to IDLE, outputs to reset values; the RAM write may be partial, no retry.

## Structure
- Constants `RamEnable`, `RamDisable`, `RamWrite`, `RamUnWrite`, `Zero`, `RstEnable` (here 1'b0) and state encodings go in shared `define.v`.
- One natural sub-module: `bus_timeout_cnt` (clear, enable, terminal-count output, parameter `TIMEOUT`).

## Test plan
- Reset released, `ifCe`=1 addr 0x0000_0040, `ramAck` 1 cycle after `ramCe` with 0x2401_0005 → `ifDone` pulse, `ifData`=0x2401_0005, `stall` low after pulse.
- Store: `memCe`=1, `memWr`=1, addr 0x100, data 0xDEAD_BEEF, ack after 3 cycles → `ramWe`=1, address/data stable 3 cycles, `memDone` once.
- `memCe` and `ifCe` asserted together → RAM sees the MEM address first, DONE bubble, then the IF address; `stall` high until `ifDone`.
- No `ramAck` with `TIMEOUT`=16 → `busErr`=1 after 16 access cycles, `memDone` pulses with `rdData`=0, FSM returns to IDLE and accepts the next request.
- `rst` pulled low during a load access → all outputs at reset values that cycle; after release, a fresh load of 0x200 returns the correct data.
- Back-to-back loads 0x10, 0x14 with data 0x1111_1111, 0x2222_2222 → two `memDone` pulses, `rdData` holds each value until the next completion.
